spi_prog_regfile: RTL and testbench

Parametrised successor to the CS-latched SPI programming shift register. Runs entirely in the system clock domain: SCLK/CS/SDI are synchronised and edge-detected. Accepts framed write and read commands, commits writes atomically to the programming word only on a well-formed frame, and supports readback on SDO. Sits between the external SPI pins and all analog/digital trim ports, which slice prog_data.

---
 rtl/spi_prog_regfile.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_spi_prog_regfile.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_prog_regfile.sv
// SPI programming register file: synchronised SPI slave with framed write/read,
// atomic commit of the programming word. Optional macro SPI_PARITY_CHECK_EN adds a write parity bit.
module spi_prog_regfile #(
  parameter int                  NUM_BITS    = 98,
  parameter logic [NUM_BITS-1:0] RESET_VALUE = {NUM_BITS{1'b0}},
  parameter int                  SYNC_STAGES = 2,
  parameter logic [7:0]          CMD_WRITE   = 8'hA5,
  parameter logic [7:0]          CMD_READ    = 8'h5A
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SCLK,
  input  logic                CS,
  input  logic                SDI,
  output logic                SDO,
  output logic                SDO_OE,
  output logic [NUM_BITS-1:0] prog_data,
  output logic                update_pulse,
  output logic                frame_err,
  output logic                busy
);

`ifdef SPI_PARITY_CHECK_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int WR_LEN = NUM_BITS + PAR_BITS;
  localparam int CNT_W  = $clog2(NUM_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] WR_LEN_C   = CNT_W'(WR_LEN);

  typedef enum logic [2:0] {
    WAIT_CS_HIGH = 3'd0,
    IDLE         = 3'd1,
    HEADER       = 3'd2,
    DATA_WR      = 3'd3,
    DATA_RD      = 3'd4,
    ERROR        = 3'd5
  } state_t;

  function automatic logic even_parity(input logic [NUM_BITS-1:0] word);
    return ^word;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] sdi_sync_r;
  logic                   sclk_hist_r;
  logic                   cs_hist_r;

  logic sclk_s, cs_s, sdi_s;
  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [6:0]            hdr_r;
  logic [NUM_BITS-1:0]   shadow_r;
  logic [WR_LEN-1:0]     rd_shift_r;
  logic [NUM_BITS-1:0]   prog_data_r;
  logic                  sdo_r, sdo_oe_r, update_r, frame_err_r, busy_r;

  logic [7:0] cmd_s;
  logic       parity_ok_s;
  logic       cnt_clr_s, cnt_inc_s, hdr_shift_s, wr_shift_s, snap_s, rd_shift_s;
  logic       commit_s, err_s;
`ifdef SPI_PARITY_CHECK_EN
  logic       par_capture_s;
  logic       par_bit_r;
`endif

  // Pin synchronisers with one history flop each for SCLK and CS edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b0}};
      sdi_sync_r  <= {SYNC_STAGES{1'b0}};
      sclk_hist_r <= 1'b0;
      cs_hist_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS};
      sdi_sync_r  <= {sdi_sync_r[SYNC_STAGES-2:0], SDI};
      sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
      cs_hist_r   <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  // CS sync flops reset low so a frame spanning reset release is held in WAIT_CS_HIGH
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_hist_r;
  assign sclk_fall_s = ~sclk_s & sclk_hist_r;
  assign cs_rise_s   = cs_s & ~cs_hist_r;
  assign cs_fall_s   = ~cs_s & cs_hist_r;

  assign cmd_s = {hdr_r, sdi_s};

`ifdef SPI_PARITY_CHECK_EN
  assign parity_ok_s = (par_bit_r == even_parity(shadow_r));
`else
  assign parity_ok_s = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= WAIT_CS_HIGH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and datapath strobes; a CS rise always takes priority over SCLK edges
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    hdr_shift_s = 1'b0;
    wr_shift_s  = 1'b0;
    snap_s      = 1'b0;
    rd_shift_s  = 1'b0;
    commit_s    = 1'b0;
    err_s       = 1'b0;
`ifdef SPI_PARITY_CHECK_EN
    par_capture_s = 1'b0;
`endif
    case (state_r)
      WAIT_CS_HIGH: begin
        if (cs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_CS_HIGH;
        end
      end
      IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s = HEADER;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HEADER: begin
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
          err_s       = 1'b1;
        end else if (sclk_rise_s) begin
          hdr_shift_s = 1'b1;
          if (bit_cnt_r == HDR_LAST) begin
            cnt_clr_s = 1'b1;
            if (cmd_s == CMD_WRITE) begin
              state_nxt_s = DATA_WR;
            end else if (cmd_s == CMD_READ) begin
              state_nxt_s = DATA_RD;
              snap_s      = 1'b1;
            end else begin
              state_nxt_s = ERROR;
            end
          end else begin
            cnt_inc_s = 1'b1;
          end
        end else begin
          state_nxt_s = HEADER;
        end
      end
      DATA_WR: begin
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
          if ((bit_cnt_r == WR_LEN_C) && parity_ok_s) begin
            commit_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else if (sclk_rise_s) begin
          if (bit_cnt_r == WR_LEN_C) begin
            state_nxt_s = ERROR;
          end else begin
            cnt_inc_s = 1'b1;
`ifdef SPI_PARITY_CHECK_EN
            if (bit_cnt_r < CNT_W'(NUM_BITS)) begin
              wr_shift_s = 1'b1;
            end else begin
              par_capture_s = 1'b1;
            end
`else
            wr_shift_s = 1'b1;
`endif
          end
        end else begin
          state_nxt_s = DATA_WR;
        end
      end
      DATA_RD: begin
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
        end else if (sclk_fall_s) begin
          rd_shift_s = 1'b1;
        end else begin
          state_nxt_s = DATA_RD;
        end
      end
      ERROR: begin
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
          err_s       = 1'b1;
        end else begin
          state_nxt_s = ERROR;
        end
      end
      default: begin
        state_nxt_s = WAIT_CS_HIGH;
      end
    endcase
  end

  // Saturating bit counter shared by header and data phases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r <= CNT_ZERO;
    end else if (cnt_clr_s) begin
      bit_cnt_r <= CNT_ZERO;
    end else if (cnt_inc_s && (bit_cnt_r != CNT_MAX)) begin
      bit_cnt_r <= bit_cnt_r + CNT_ONE;
    end
  end

  // Header, shadow and read shifters; shadow fills from the top so frame bit k ends at [k]
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_r      <= 7'd0;
      shadow_r   <= {NUM_BITS{1'b0}};
      rd_shift_r <= {WR_LEN{1'b0}};
    end else begin
      if (hdr_shift_s) begin
        hdr_r <= {hdr_r[5:0], sdi_s};
      end
      if (wr_shift_s) begin
        shadow_r <= {sdi_s, shadow_r[NUM_BITS-1:1]};
      end
      if (snap_s) begin
`ifdef SPI_PARITY_CHECK_EN
        rd_shift_r <= {even_parity(prog_data_r), prog_data_r};
`else
        rd_shift_r <= prog_data_r;
`endif
      end else if (rd_shift_s) begin
        rd_shift_r <= {1'b0, rd_shift_r[WR_LEN-1:1]};
      end
    end
  end

`ifdef SPI_PARITY_CHECK_EN
  // Trailing parity bit of a write frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit_r <= 1'b0;
    end else if (par_capture_s) begin
      par_bit_r <= sdi_s;
    end
  end
`endif

  // Registered outputs; prog_data changes only on commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_data_r <= RESET_VALUE;
      sdo_r       <= 1'b0;
      sdo_oe_r    <= 1'b0;
      update_r    <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (commit_s) begin
        prog_data_r <= shadow_r;
      end
      if (state_nxt_s != DATA_RD) begin
        sdo_r <= 1'b0;
      end else if (rd_shift_s) begin
        sdo_r <= rd_shift_r[0];
      end
      sdo_oe_r    <= (state_nxt_s == DATA_RD);
      update_r    <= commit_s;
      frame_err_r <= err_s;
      busy_r      <= (state_nxt_s inside {HEADER, DATA_WR, DATA_RD, ERROR});
    end
  end

  assign prog_data    = prog_data_r;
  assign SDO          = sdo_r;
  assign SDO_OE       = sdo_oe_r;
  assign update_pulse = update_r;
  assign frame_err    = frame_err_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_spi_prog_regfile.sv
// Directed bench for spi_prog_regfile (NUM_BITS=16): vector table of write frames
// plus hand sequences for commit timing, readback and reset mid-frame.
module tb_spi_prog_regfile;

  localparam int          NB = 16;
  localparam logic [15:0] RV = 16'hC3A5;
`ifdef SPI_PARITY_CHECK_EN
  localparam int WL = 17;
  localparam int NV = 10;
`else
  localparam int WL = 16;
  localparam int NV = 8;
`endif

  logic          clk = 1'b0;
  logic          reset, SCLK, CS, SDI;
  logic          SDO, SDO_OE, update_pulse, frame_err, busy;
  logic [NB-1:0] prog_data;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    string       name;
    logic [7:0]  hdr;
    int          hbits;
    int          dbits;
    logic [31:0] data;
    logic [15:0] exp_pd;
    int          exp_upd;
    int          exp_err;
  } vec_t;

  vec_t vt[NV];

  spi_prog_regfile #(
    .NUM_BITS(NB), .RESET_VALUE(RV), .SYNC_STAGES(2),
    .CMD_WRITE(8'hA5), .CMD_READ(8'h5A)
  ) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .SDI(SDI),
    .SDO(SDO), .SDO_OE(SDO_OE), .prog_data(prog_data),
    .update_pulse(update_pulse), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update_pulse === 1'b1) upd_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  function automatic logic [31:0] wr_word(input logic [15:0] d);
`ifdef SPI_PARITY_CHECK_EN
    return {15'd0, ^d, d};
`else
    return {16'd0, d};
`endif
  endfunction

  function automatic vec_t mk(input string nm, input logic [7:0] h, input int hb, input int db,
                              input logic [31:0] d, input logic [15:0] pd, input int u, input int e);
    vec_t v;
    v.name = nm; v.hdr = h; v.hbits = hb; v.dbits = db; v.data = d;
    v.exp_pd = pd; v.exp_upd = u; v.exp_err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    SDI = b;
    #50 SCLK = 1'b1;
    #50 SCLK = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input int n, input bit msb_first);
    for (int i = 0; i < n; i++) begin
      bit_out(msb_first ? d[n-1-i] : d[i]);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    CS = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #100;
    @(negedge clk);
    CS = 1'b1;
    #200;
  endtask

  task automatic rd_frame(input int n, output logic [31:0] got, output logic oe_hdr,
                          output logic oe_all, output logic busy_all);
    cs_low();
    oe_hdr = SDO_OE;
    send(32'h0000_005A, 8, 1'b1);
    got = 32'd0; oe_all = 1'b1; busy_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      #40;
      got[i] = SDO;
      oe_all &= SDO_OE;
      busy_all &= busy;
      #10 SCLK = 1'b1;
      #50 SCLK = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] got;
    logic        oe_hdr, oe_all, busy_all;
    logic [15:0] last_pd;
    int          u0, e0;

    vt[0] = mk("short_wr",  8'hA5, 8, WL-1, wr_word(16'h1234), 16'hBEEF, 0, 1);
    vt[1] = mk("overrun",   8'hA5, 8, WL+1, wr_word(16'hFFFF), 16'hBEEF, 0, 1);
    vt[2] = mk("bad_hdr00", 8'h00, 8, WL,   wr_word(16'h1111), 16'hBEEF, 0, 1);
    vt[3] = mk("hdr_short", 8'hA5, 4, 0,    32'd0,             16'hBEEF, 0, 1);
    vt[4] = mk("no_data",   8'hA5, 8, 0,    32'd0,             16'hBEEF, 0, 1);
    vt[5] = mk("wr_5a5a",   8'hA5, 8, WL,   wr_word(16'h5A5A), 16'h5A5A, 1, 0);
    vt[6] = mk("wr_8001",   8'hA5, 8, WL,   wr_word(16'h8001), 16'h8001, 1, 0);
    vt[7] = mk("bad_hdrA4", 8'hA4, 8, WL,   wr_word(16'h7777), 16'h8001, 0, 1);
`ifdef SPI_PARITY_CHECK_EN
    vt[8] = mk("par_ok",    8'hA5, 8, 17,   {15'd0, 1'b1, 16'h0001}, 16'h0001, 1, 0);
    vt[9] = mk("par_bad",   8'hA5, 8, 17,   {15'd0, 1'b1, 16'h0003}, 16'h0001, 0, 1);
`endif

    reset = 1'b1; CS = 1'b1; SCLK = 1'b0; SDI = 1'b0;
    #32;
    check("rst_prog_data", prog_data, RV);
    check("rst_sdo", SDO, 1'b0);
    check("rst_sdo_oe", SDO_OE, 1'b0);
    check("rst_update", update_pulse, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #200;

    // Write BEEF and check the commit timing cycle by cycle
    u0 = upd_cnt; e0 = err_cnt;
    cs_low();
    check("t1_busy_in_frame", busy, 1'b1);
    send(32'h0000_00A5, 8, 1'b1);
    send(wr_word(16'hBEEF), WL, 1'b0);
    #100;
    @(negedge clk);
    CS = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t1_no_early_pulse", update_pulse, 1'b0);
    check("t1_no_early_commit", prog_data, RV);
    @(negedge clk);
    check("t1_pulse", update_pulse, 1'b1);
    check("t1_commit", prog_data, 16'hBEEF);
    check("t1_busy_clear", busy, 1'b0);
    @(negedge clk);
    check("t1_pulse_one_clk", update_pulse, 1'b0);
    #200;
    check("t1_upd_count", upd_cnt - u0, 1);
    check("t1_no_err", err_cnt - e0, 0);

    // Readback including two extra clocks that must shift out zeros
    e0 = err_cnt;
    rd_frame(WL + 2, got, oe_hdr, oe_all, busy_all);
    cs_high();
    check("t2_oe_hdr", oe_hdr, 1'b0);
    check("t2_rd_data", got, wr_word(16'hBEEF));
    check("t2_oe_data", oe_all, 1'b1);
    check("t2_busy_data", busy_all, 1'b1);
    check("t2_oe_after", SDO_OE, 1'b0);
    check("t2_sdo_after", SDO, 1'b0);
    check("t2_prog_kept", prog_data, 16'hBEEF);
    check("t2_no_err", err_cnt - e0, 0);

    last_pd = 16'hBEEF;
    for (int i = 0; i < NV; i++) begin
      u0 = upd_cnt; e0 = err_cnt;
      cs_low();
      send({24'd0, vt[i].hdr} >> (8 - vt[i].hbits), vt[i].hbits, 1'b1);
      send(vt[i].data, vt[i].dbits, 1'b0);
      cs_high();
      check({vt[i].name, "_prog"}, prog_data, vt[i].exp_pd);
      check({vt[i].name, "_upd"}, upd_cnt - u0, vt[i].exp_upd);
      check({vt[i].name, "_err"}, err_cnt - e0, vt[i].exp_err);
      last_pd = vt[i].exp_pd;
    end

    // Full readback of the latest word, then a legal partial read
    e0 = err_cnt;
    rd_frame(WL, got, oe_hdr, oe_all, busy_all);
    cs_high();
    check("rd2_data", got, wr_word(last_pd));
    rd_frame(8, got, oe_hdr, oe_all, busy_all);
    cs_high();
    check("rd_partial_data", got, {24'd0, last_pd[7:0]});
    check("rd_no_err", err_cnt - e0, 0);
    check("rd_prog_kept", prog_data, last_pd);

    // Reset after 10 data bits, released with CS still low
    u0 = upd_cnt; e0 = err_cnt;
    cs_low();
    send(32'h0000_00A5, 8, 1'b1);
    send(wr_word(16'h2468), 10, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst_prog", prog_data, RV);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_oe", SDO_OE, 1'b0);
    #30;
    @(negedge clk);
    reset = 1'b0;
    #40;
    check("t5_wait_busy", busy, 1'b0);
    send(wr_word(16'h2468) >> 10, WL - 10, 1'b0);
    cs_high();
    check("t5_prog_reset_val", prog_data, RV);
    check("t5_no_upd", upd_cnt - u0, 0);
    check("t5_no_err", err_cnt - e0, 0);

    u0 = upd_cnt; e0 = err_cnt;
    cs_low();
    send(32'h0000_00A5, 8, 1'b1);
    send(wr_word(16'h1357), WL, 1'b0);
    cs_high();
    check("t5_next_commit", prog_data, 16'h1357);
    check("t5_next_upd", upd_cnt - u0, 1);
    check("t5_next_err", err_cnt - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
